call_button_conditioner: RTL and testbench

//   Front-end conditioner for the flight attendant call system. Takes raw, asynchronous

---
 rtl/call_button_if.sv | 23 ++
 rtl/call_button_conditioner.sv | 95 +++++++++
 tb/tb_call_button_conditioner.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/call_button_if.sv
// Call/cancel pushbutton bundle: raw asynchronous inputs and conditioned outputs.
interface call_button_if;
  logic call_raw;
  logic cancel_raw;
  logic call_button;
  logic cancel_button;
  logic call_pulse;
  logic cancel_pulse;
  logic call_stuck;
  logic cancel_stuck;

  // Button side drives the raw levels and observes the conditioned outputs
  modport master (
    output call_raw, cancel_raw,
    input  call_button, cancel_button, call_pulse, cancel_pulse, call_stuck, cancel_stuck
  );

  // Conditioner side
  modport slave (
    input  call_raw, cancel_raw,
    output call_button, cancel_button, call_pulse, cancel_pulse, call_stuck, cancel_stuck
  );
endinterface

// File: rtl/call_button_conditioner.sv
// Synchronize, debounce, edge-detect and stuck-detect the call and cancel pushbuttons.
// Channel 0 is call, channel 1 is cancel; the two channels share no state.
module call_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STUCK_CYCLES    = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  call_button_if.slave  btn
);

  localparam int unsigned NCH    = 2;
  localparam int unsigned CNT_W  = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SCNT_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STUCK_CYCLES);

  logic [NCH-1:0]    raw_c;
  logic [NCH-1:0]    s1_q, s1_d;
  logic [NCH-1:0]    s2_q, s2_d;
  logic [NCH-1:0]    level_q, level_d;
  logic [NCH-1:0]    pulse_q, pulse_d;
  logic [NCH-1:0]    stuck_q, stuck_d;
  logic [CNT_W-1:0]  cnt_q  [NCH];
  logic [CNT_W-1:0]  cnt_d  [NCH];
  logic [SCNT_W-1:0] scnt_q [NCH];
  logic [SCNT_W-1:0] scnt_d [NCH];

  assign raw_c = {btn.cancel_raw, btn.call_raw};

  // Next-state: sync pipeline, debounce counter, rise pulse and saturating stuck counter
  always_comb begin
    s1_d    = raw_c;
    s2_d    = s1_q;
    level_d = level_q;
    pulse_d = '0;
    stuck_d = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      cnt_d[ch]  = cnt_q[ch];
      scnt_d[ch] = scnt_q[ch];
    end
    for (int ch = 0; ch < NCH; ch++) begin
      // Any cycle agreeing with the accepted level restarts the stability count
      if (s2_q[ch] == level_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CNT_MAX) begin
        level_d[ch] = s2_q[ch];
        cnt_d[ch]   = '0;
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
      pulse_d[ch] = level_d[ch] & ~level_q[ch];
      // Stuck counter tracks how long the accepted level has been high
      if (!level_q[ch]) begin
        scnt_d[ch] = '0;
      end else if (scnt_q[ch] != SCNT_MAX) begin
        scnt_d[ch] = scnt_q[ch] + SCNT_W'(1);
      end
      stuck_d[ch] = (scnt_d[ch] == SCNT_MAX);
    end
  end

  // State registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      pulse_q <= '0;
      stuck_q <= '0;
      for (int ch = 0; ch < NCH; ch++) begin
        cnt_q[ch]  <= '0;
        scnt_q[ch] <= '0;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      stuck_q <= stuck_d;
      for (int ch = 0; ch < NCH; ch++) begin
        cnt_q[ch]  <= cnt_d[ch];
        scnt_q[ch] <= scnt_d[ch];
      end
    end
  end

  assign btn.call_button   = level_q[0];
  assign btn.cancel_button = level_q[1];
  assign btn.call_pulse    = pulse_q[0];
  assign btn.cancel_pulse  = pulse_q[1];
  assign btn.call_stuck    = stuck_q[0];
  assign btn.cancel_stuck  = stuck_q[1];

endmodule

// File: tb/tb_call_button_conditioner.sv
// Bench for call_button_conditioner: directed scenarios with literal expectations plus
// randomized bouncy inputs checked every cycle against a history-window reference model.
module tb_call_button_conditioner;

  localparam int D    = 4;
  localparam int S    = 16;
  localparam int MAXE = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  call_button_if bif ();

  call_button_conditioner #(.DEBOUNCE_CYCLES(D), .STUCK_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: per-edge raw samples and accepted levels since reset release
  int       e = 0;
  bit       raw_h [2][MAXE];
  bit       lvl_h [2][MAXE];
  int       lastflip [2];
  logic [2:0] exp_v [2];
  logic [2:0] got_v [2];
  int       pulse_seen [2];

  function automatic bit samp(int ch, int i);
    return (i >= 1) ? raw_h[ch][i] : 1'b0;
  endfunction

  function automatic bit lv(int ch, int i);
    return (i >= 1) ? lvl_h[ch][i] : 1'b0;
  endfunction

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, expv, $time);
    end
  endtask

  // Model: level flips once the last D synchronized samples (all taken after the previous
  // flip) disagree with it; stuck means level was high for each of the previous S edges.
  always @(posedge clk) begin
    if (!rst_n) begin
      e = 0;
      lastflip[0] = 0;
      lastflip[1] = 0;
      lvl_h[0][0] = 1'b0;
      lvl_h[1][0] = 1'b0;
    end else if (e < MAXE - 1) begin
      e++;
      raw_h[0][e] = bif.call_raw;
      raw_h[1][e] = bif.cancel_raw;
      for (int ch = 0; ch < 2; ch++) begin
        bit prev, flip, stk;
        prev = lvl_h[ch][e-1];
        flip = (e - D - 1 >= lastflip[ch] - 1);
        for (int j = 0; j < D; j++)
          if (samp(ch, e - 2 - j) == prev) flip = 1'b0;
        lvl_h[ch][e] = flip ? ~prev : prev;
        if (flip) lastflip[ch] = e;
        stk = 1'b1;
        for (int k = e - S; k < e; k++)
          if (!lv(ch, k)) stk = 1'b0;
        exp_v[ch] = {lvl_h[ch][e], lvl_h[ch][e] & ~prev, stk};
      end
      #1;
      if (rst_n) begin
        got_v[0] = {bif.call_button, bif.call_pulse, bif.call_stuck};
        got_v[1] = {bif.cancel_button, bif.cancel_pulse, bif.cancel_stuck};
        for (int ch = 0; ch < 2; ch++) begin
          checks++;
          if (got_v[ch] !== exp_v[ch]) begin
            failures++;
            $display("FAIL model_ch%0d edge=%0d {level,pulse,stuck} got=%b expected=%b",
                     ch, e, got_v[ch], exp_v[ch]);
          end
          pulse_seen[ch] += int'(got_v[ch][1]);
        end
      end
    end
  end

  function automatic logic get_sig(int sel);
    case (sel)
      0: return bif.call_button;
      1: return bif.cancel_button;
      2: return bif.call_pulse;
      3: return bif.cancel_pulse;
      4: return bif.call_stuck;
      default: return bif.cancel_stuck;
    endcase
  endfunction

  // Count rising edges until the selected output reaches val; -1 if the budget expires
  task automatic wait_sig(input int sel, input logic val, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(posedge clk);
      #1;
      n++;
      if (get_sig(sel) === val) return;
    end
    n = -1;
  endtask

  function automatic logic [5:0] all_outs();
    return {bif.call_button, bif.cancel_button, bif.call_pulse,
            bif.cancel_pulse, bif.call_stuck, bif.cancel_stuck};
  endfunction

  initial begin
    int n, p0, p1;
    logic flag;
    int run [2];

    bif.call_raw   = 1'b0;
    bif.cancel_raw = 1'b0;
    pulse_seen[0]  = 0;
    pulse_seen[1]  = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", int'(all_outs()), 0);

    // Clean press and release of call
    @(negedge clk) bif.call_raw = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    chk("t2_press_latency", n, 6);
    chk("t2_pulse_on", int'(bif.call_pulse), 1);
    @(posedge clk); #1;
    chk("t2_pulse_off", int'(bif.call_pulse), 0);
    p0 = pulse_seen[0];
    @(negedge clk) bif.call_raw = 1'b0;
    wait_sig(0, 1'b0, 20, n);
    chk("t2_release_latency", n, 6);
    repeat (5) @(negedge clk);
    chk("t2_no_release_pulse", pulse_seen[0] - p0, 0);

    // Bouncing cancel
    p1 = pulse_seen[1];
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      flag = flag | bif.cancel_button;
      if (i % 2 == 0) bif.cancel_raw = ~bif.cancel_raw;
    end
    @(negedge clk);
    flag = flag | bif.cancel_button;
    bif.cancel_raw = 1'b1;
    chk("t3_no_level_while_bouncing", int'(flag), 0);
    wait_sig(1, 1'b1, 20, n);
    chk("t3_settle_latency", n, 6);
    repeat (5) @(negedge clk);
    chk("t3_single_pulse", pulse_seen[1] - p1, 1);
    bif.cancel_raw = 1'b0;
    repeat (10) @(negedge clk);

    // Short glitch on call
    p0 = pulse_seen[0];
    flag = 1'b0;
    bif.call_raw = 1'b1;
    repeat (3) @(negedge clk);
    bif.call_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      flag = flag | bif.call_button | bif.call_pulse;
    end
    chk("t4_glitch_rejected", int'(flag), 0);
    chk("t4_no_pulse", pulse_seen[0] - p0, 0);

    // Simultaneous press
    @(negedge clk);
    bif.call_raw   = 1'b1;
    bif.cancel_raw = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    chk("t5_latency", n, 6);
    chk("t5_both_same_cycle", int'({bif.cancel_button, bif.call_pulse, bif.cancel_pulse}), 7);
    @(negedge clk);
    bif.call_raw   = 1'b0;
    bif.cancel_raw = 1'b0;
    repeat (10) @(negedge clk);

    // Stuck call
    bif.call_raw = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    chk("t6_rise", n, 6);
    wait_sig(4, 1'b1, 40, n);
    chk("t6_stuck_latency", n, S);
    repeat (10) @(negedge clk);
    chk("t6_stuck_holds", int'({bif.call_stuck, bif.cancel_stuck}), 2);
    bif.call_raw = 1'b0;
    wait_sig(0, 1'b0, 20, n);
    chk("t6_fall", n, 6);
    chk("t6_stuck_at_fall", int'(bif.call_stuck), 1);
    @(posedge clk); #1;
    chk("t6_stuck_clears", int'(bif.call_stuck), 0);
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-activity, then recovery with call held
    bif.call_raw = 1'b1;
    repeat (30) @(negedge clk);
    chk("t1_pre_reset", int'({bif.call_button, bif.call_stuck}), 3);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t1_async_clear", int'(all_outs()), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    chk("t1_release_latency", n, 6);
    chk("t1_pulse_on", int'(bif.call_pulse), 1);
    @(posedge clk); #1;
    chk("t1_pulse_off", int'(bif.call_pulse), 0);
    @(negedge clk) bif.call_raw = 1'b0;
    repeat (10) @(negedge clk);

    // Randomized bouncy inputs with occasional long holds and one reset
    run[0] = 0;
    run[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) rst_n = 1'b0;
      if (c == 1502) rst_n = 1'b1;
      for (int ch = 0; ch < 2; ch++) begin
        if (run[ch] == 0) begin
          if (ch == 0) bif.call_raw = ~bif.call_raw;
          else         bif.cancel_raw = ~bif.cancel_raw;
          run[ch] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(20, 40))
                                                : int'($urandom_range(1, 8));
        end else begin
          run[ch]--;
        end
      end
    end
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
